ga23_rom_responder: RTL and testbench

//  Responder side of the GA23 tile-ROM fetch channels. It serves four toggle-handshake

---
 rtl/ga23_rom_responder_if.sv | 26 ++
 rtl/ga23_rom_responder.sv | 120 ++++++++++++
 tb/tb_ga23_rom_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ga23_rom_responder_if.sv
// GA23 tile-ROM fetch bus: four toggle-handshake request channels plus the memory read port.
// The responder uses the slave modport; requesters and the memory model use master.
interface ga23_rom_responder_if #(
   parameter int unsigned ADDR_W = 24,
   parameter int unsigned DATA_W = 32
);
   logic [3:0]          chan_req;
   logic [4*ADDR_W-1:0] chan_addr;
   logic [3:0]          chan_ack;
   logic [4*DATA_W-1:0] chan_data;
   logic                mem_rd;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_rdy;
   logic                mem_valid;
   logic [DATA_W-1:0]   mem_q;

   modport slave (
      input  chan_req, chan_addr, mem_rdy, mem_valid, mem_q,
      output chan_ack, chan_data, mem_rd, mem_addr
   );

   modport master (
      output chan_req, chan_addr, mem_rdy, mem_valid, mem_q,
      input  chan_ack, chan_data, mem_rd, mem_addr
   );
endinterface

// File: rtl/ga23_rom_responder.sv
// GA23 tile-ROM responder: arbitrates four toggle-handshake channels onto one read port.
// Optional per-channel single-entry cache is enabled by defining ROM_CACHE_EN.
module ga23_rom_responder #(
   parameter int unsigned ADDR_W     = 24,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned PRIO_FIXED = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cache_flush,
   output logic                 busy,
   ga23_rom_responder_if.slave  bus
);
   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e            state;
   logic [1:0]        grant;
   logic [1:0]        rr_last;
   logic [3:0]        pending;
   logic [ADDR_W-1:0] addr_arr [4];
   logic              win_vld;
   logic [1:0]        win;
   logic [1:0]        idx;
   logic              hit;

   assign pending = bus.chan_req ^ bus.chan_ack;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         addr_arr[i] = bus.chan_addr[i*ADDR_W +: ADDR_W];
      end
   end

   // Scan the order backwards so the earliest pending channel in the order wins.
   always_comb begin
      win_vld = 1'b0;
      win     = 2'd0;
      idx     = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         idx = (PRIO_FIXED != 0) ? 2'(k - 1) : 2'(rr_last + 2'(k));
         if (pending[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

`ifdef ROM_CACHE_EN
   logic [ADDR_W-1:0] tag [4];
   logic [3:0]        tag_vld;

   assign hit = tag_vld[win] && (tag[win] == addr_arr[win]) && !cache_flush;
`else
   logic unused_flush;

   assign hit          = 1'b0;
   assign unused_flush = cache_flush;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= StIdle;
         grant         <= 2'd0;
         rr_last       <= 2'd3;
         busy          <= 1'b0;
         bus.chan_ack  <= '0;
         bus.chan_data <= '0;
         bus.mem_rd    <= 1'b0;
         bus.mem_addr  <= '0;
`ifdef ROM_CACHE_EN
         tag_vld       <= '0;
         for (int i = 0; i < 4; i++) tag[i] <= '0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (win_vld) begin
                  if (hit) begin
                     bus.chan_ack[win] <= bus.chan_req[win];
                     rr_last           <= win;
                  end else begin
                     grant        <= win;
                     bus.mem_addr <= addr_arr[win];
                     bus.mem_rd   <= 1'b1;
                     busy         <= 1'b1;
                     state        <= StIssue;
                  end
               end
            end
            StIssue: begin
               if (bus.mem_rdy) begin
                  bus.mem_rd <= 1'b0;
                  state      <= StWait;
               end
            end
            StWait: begin
               if (bus.mem_valid) begin
                  bus.chan_data[grant*DATA_W +: DATA_W] <= bus.mem_q;
                  bus.chan_ack[grant]                   <= bus.chan_req[grant];
                  rr_last                               <= grant;
                  busy                                  <= 1'b0;
                  state                                 <= StIdle;
`ifdef ROM_CACHE_EN
                  tag[grant]     <= bus.mem_addr;
                  tag_vld[grant] <= 1'b1;
`endif
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
`ifdef ROM_CACHE_EN
         // Flush overrides a fill landing on the same edge.
         if (cache_flush) tag_vld <= '0;
`endif
      end
   end
endmodule

// File: tb/tb_ga23_rom_responder.sv
// Directed bench for ga23_rom_responder: round-robin instance plus a fixed-priority instance.
module tb_ga23_rom_responder;
   logic clk;
   logic reset_n;
   logic cache_flush;
   logic busy;
   logic busy_f;
   int   checks;
   int   failures;

   ga23_rom_responder_if #(.ADDR_W(24), .DATA_W(32)) bus ();
   ga23_rom_responder_if #(.ADDR_W(24), .DATA_W(32)) bus_f ();

   ga23_rom_responder #(.ADDR_W(24), .DATA_W(32), .PRIO_FIXED(0)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cache_flush (cache_flush),
      .busy        (busy),
      .bus         (bus.slave)
   );

   ga23_rom_responder #(.ADDR_W(24), .DATA_W(32), .PRIO_FIXED(1)) u_fix (
      .clk         (clk),
      .reset_n     (reset_n),
      .cache_flush (cache_flush),
      .busy        (busy_f),
      .bus         (bus_f.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_n         = 1'b0;
      cache_flush     = 1'b0;
      bus.chan_req    = '0;
      bus.mem_rdy     = 1'b0;
      bus.mem_valid   = 1'b0;
      bus.mem_q       = '0;
      bus_f.chan_req  = '0;
      bus_f.mem_rdy   = 1'b0;
      bus_f.mem_valid = 1'b0;
      bus_f.mem_q     = '0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Memory model: wait for a read, accept it, return q one cycle after accept.
   task automatic serve(input bit fix, input logic [23:0] exp_addr, input logic [31:0] q,
                        input string tag);
      int n;
      n = 0;
      while (!(fix ? bus_f.mem_rd : bus.mem_rd) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rd"}, fix ? bus_f.mem_rd : bus.mem_rd, 1);
      chk({tag, "_addr"}, fix ? bus_f.mem_addr : bus.mem_addr, exp_addr);
      if (fix) bus_f.mem_rdy = 1'b1;
      else     bus.mem_rdy = 1'b1;
      @(negedge clk);
      bus.mem_rdy   = 1'b0;
      bus_f.mem_rdy = 1'b0;
      chk({tag, "_wait_busy"}, fix ? busy_f : busy, 1);
      if (fix) begin
         bus_f.mem_valid = 1'b1;
         bus_f.mem_q     = q;
      end else begin
         bus.mem_valid = 1'b1;
         bus.mem_q     = q;
      end
      @(negedge clk);
      bus.mem_valid   = 1'b0;
      bus_f.mem_valid = 1'b0;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      bus.chan_addr   = '0;
      bus_f.chan_addr = '0;
      do_reset();

      // Reset state
      chk("rst_ack", bus.chan_ack, 4'h0);
      chk("rst_data", bus.chan_data, 128'h0);
      chk("rst_rd", bus.mem_rd, 0);
      chk("rst_addr", bus.mem_addr, 24'h0);
      chk("rst_busy", busy, 0);

      // 1: single read, latency 3 edges from the toggle
      bus.chan_addr[0 +: 24] = 24'h001234;
      bus.chan_req[0] = 1'b1;
      @(negedge clk);
      chk("t1_issue_rd", bus.mem_rd, 1);
      chk("t1_issue_ack", bus.chan_ack, 4'h0);
      serve(1'b0, 24'h001234, 32'hDEADBEEF, "t1");
      chk("t1_ack", bus.chan_ack, 4'h1);
      chk("t1_data", bus.chan_data[0 +: 32], 32'hDEADBEEF);
      chk("t1_idle", busy, 0);

      // 2: four simultaneous requests, then ch0 rejoins behind ch3
      do_reset();
      bus.chan_addr[0 +: 24]  = 24'h000010;
      bus.chan_addr[24 +: 24] = 24'h000020;
      bus.chan_addr[48 +: 24] = 24'h000030;
      bus.chan_addr[72 +: 24] = 24'h000040;
      bus.chan_req = 4'hF;
      serve(1'b0, 24'h000010, 32'hA0A0A0A0, "t2_c0");
      chk("t2_ack0", bus.chan_ack, 4'h1);
      bus.chan_req[0] = 1'b0;
      serve(1'b0, 24'h000020, 32'hA1A1A1A1, "t2_c1");
      serve(1'b0, 24'h000030, 32'hA2A2A2A2, "t2_c2");
      serve(1'b0, 24'h000040, 32'hA3A3A3A3, "t2_c3");
      chk("t2_ack_mid", bus.chan_ack, 4'hF);
      serve(1'b0, 24'h000010, 32'hB0B0B0B0, "t2_c0b");
      chk("t2_ack_end", bus.chan_ack, 4'hE);
      chk("t2_data", bus.chan_data, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hB0B0B0B0});

      // 3: memory stalls for 5 cycles
      do_reset();
      bus.chan_addr[24 +: 24] = 24'h0055AA;
      bus.chan_req[1] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("t3_stall_rd", bus.mem_rd, 1);
         chk("t3_stall_addr", bus.mem_addr, 24'h0055AA);
         chk("t3_stall_busy", busy, 1);
         @(negedge clk);
      end
      serve(1'b0, 24'h0055AA, 32'h12345678, "t3");
      chk("t3_ack", bus.chan_ack, 4'h2);
      chk("t3_data", bus.chan_data[32 +: 32], 32'h12345678);
      @(negedge clk);
      @(negedge clk);
      chk("t3_one_read", bus.mem_rd, 0);

      // 4: reset during WAIT, then a stale mem_valid in IDLE
      bus.chan_addr[48 +: 24] = 24'h000777;
      bus.chan_req[2] = 1'b1;
      @(negedge clk);
      chk("t4_rd", bus.mem_rd, 1);
      bus.mem_rdy = 1'b1;
      @(negedge clk);
      bus.mem_rdy = 1'b0;
      chk("t4_wait_busy", busy, 1);
      reset_n = 1'b0;
      bus.chan_req = '0;
      #1;
      chk("t4_rst_ack", bus.chan_ack, 4'h0);
      chk("t4_rst_data", bus.chan_data, 128'h0);
      chk("t4_rst_addr", bus.mem_addr, 24'h0);
      chk("t4_rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_q     = 32'h0BAD0BAD;
      @(negedge clk);
      bus.mem_valid = 1'b0;
      @(negedge clk);
      chk("t4_stale_data", bus.chan_data, 128'h0);
      chk("t4_stale_ack", bus.chan_ack, 4'h0);
      chk("t4_stale_rd", bus.mem_rd, 0);
      chk("t4_stale_busy", busy, 0);

      // 5: fixed priority, ch0 keeps re-toggling while ch3 waits
      bus_f.chan_addr[0 +: 24]  = 24'h000100;
      bus_f.chan_addr[72 +: 24] = 24'h000300;
      bus_f.chan_req = 4'h9;
      serve(1'b1, 24'h000100, 32'hC0000001, "t5_a");
      bus_f.chan_req[0] = ~bus_f.chan_req[0];
      serve(1'b1, 24'h000100, 32'hC0000002, "t5_b");
      bus_f.chan_req[0] = ~bus_f.chan_req[0];
      serve(1'b1, 24'h000100, 32'hC0000003, "t5_c");
      chk("t5_ch3_starved", bus_f.chan_ack[3], 0);
      serve(1'b1, 24'h000300, 32'hC3C3C3C3, "t5_d");
      chk("t5_ack", bus_f.chan_ack, 4'h9);
      chk("t5_data3", bus_f.chan_data[96 +: 32], 32'hC3C3C3C3);

      // 6: repeated address on ch2
      do_reset();
      bus.chan_addr[48 +: 24] = 24'h0ABCDE;
      bus.chan_req[2] = 1'b1;
      serve(1'b0, 24'h0ABCDE, 32'h600D600D, "t6_fill");
      chk("t6_ack_fill", bus.chan_ack, 4'h4);
      bus.chan_req[2] = 1'b0;
`ifdef ROM_CACHE_EN
      @(negedge clk);
      chk("t6_hit_ack", bus.chan_ack, 4'h0);
      chk("t6_hit_rd", bus.mem_rd, 0);
      chk("t6_hit_data", bus.chan_data[64 +: 32], 32'h600D600D);
      cache_flush = 1'b1;
      @(negedge clk);
      cache_flush = 1'b0;
      bus.chan_req[2] = 1'b1;
      serve(1'b0, 24'h0ABCDE, 32'h5EC0DD01, "t6_flushed");
      chk("t6_ack_end", bus.chan_ack, 4'h4);
      chk("t6_data_end", bus.chan_data[64 +: 32], 32'h5EC0DD01);
`else
      serve(1'b0, 24'h0ABCDE, 32'h5EC0DD01, "t6_nocache");
      chk("t6_ack_end", bus.chan_ack, 4'h0);
      chk("t6_data_end", bus.chan_data[64 +: 32], 32'h5EC0DD01);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
